// File: rtl/si3000_frame_scheduler.sv
// si3000_frame_scheduler
// Builds the SDI word for each Si3000 frame and classifies the captured SDO word.
// Primary frames carry DAC/ADC audio and secondary frames carry one control-register
// access, requested through the LSB of the primary word.
module si3000_frame_scheduler #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned WORD_SIZE  = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sync_reset,
    input  logic [WORD_SIZE-1:0] dac_data,
    input  logic                 dac_valid,
    output logic                 dac_ready,
    output logic [WORD_SIZE-1:0] adc_data,
    output logic                 adc_valid,
    input  logic                 cmd_req,
    input  logic                 cmd_rw,
    input  logic [4:0]           cmd_addr,
    input  logic [7:0]           cmd_wdata,
    output logic                 cmd_ready,
    output logic                 cmd_ack,
    output logic [7:0]           cmd_rdata,
    output logic                 dac_underrun,
    output logic [WORD_SIZE-1:0] codec_write_data,
    input  logic                 codec_fsync,
    input  logic                 codec_write_data_grasp,
    input  logic [WORD_SIZE-1:0] codec_read_data,
    input  logic                 codec_done
);

    localparam int unsigned    PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

    localparam logic [0:0] S_PRI = 1'b0;
    localparam logic [0:0] S_SEC = 1'b1;

    logic [WORD_SIZE-1:0] fifo_mem [FIFO_DEPTH];

    logic [0:0]           state_q,          state_d;
    logic [PTR_W-1:0]     rd_ptr_q,         rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q,         wr_ptr_d;
    logic [PTR_W:0]       count_q,          count_d;
    logic [WORD_SIZE-1:0] hold_q,           hold_d;
    logic [0:0]           snap_type_q,      snap_type_d;
    logic                 snap_from_fifo_q, snap_from_fifo_d;
    logic                 snap_sec_req_q,   snap_sec_req_d;
    logic [0:0]           inflight_type_q,  inflight_type_d;
    logic                 grasped_q,        grasped_d;
    logic                 done_d1_q,        done_d1_d;
    logic                 cmd_pending_q,    cmd_pending_d;
    logic                 cmd_inflight_q,   cmd_inflight_d;
    logic                 cmd_rw_q,         cmd_rw_d;
    logic [4:0]           cmd_addr_q,       cmd_addr_d;
    logic [7:0]           cmd_wdata_q,      cmd_wdata_d;
    logic [7:0]           cmd_rdata_q,      cmd_rdata_d;
    logic                 cmd_ack_q,        cmd_ack_d;
    logic [WORD_SIZE-1:0] adc_data_q,       adc_data_d;
    logic                 adc_valid_q,      adc_valid_d;
    logic                 underrun_q,       underrun_d;

    logic                 fifo_nonempty;
    logic                 push;
    logic                 pop;
    logic                 done_rise;
    logic [WORD_SIZE-1:0] src;
    logic                 unused_src_lsb;

    assign fifo_nonempty  = (count_q != '0);
    assign dac_ready      = (count_q != DEPTH_C);
    assign cmd_ready      = ~(cmd_pending_q | cmd_inflight_q | cmd_ack_q);
    assign push           = dac_valid & dac_ready;
    assign done_rise      = codec_done & ~done_d1_q;
    assign src            = fifo_nonempty ? fifo_mem[rd_ptr_q] : hold_q;
    // Sample LSB is always overwritten by the secondary-request flag.
    assign unused_src_lsb = src[0];

    assign adc_data     = adc_data_q;
    assign adc_valid    = adc_valid_q;
    assign cmd_ack      = cmd_ack_q;
    assign cmd_rdata    = cmd_rdata_q;
    assign dac_underrun = underrun_q;

    // SDI word for the frame the core will load next.
    always_comb begin
        if (state_q == S_PRI) begin
            codec_write_data = {src[WORD_SIZE-1:1], cmd_pending_q};
        end else begin
            codec_write_data = {2'b00, cmd_rw_q, cmd_addr_q, cmd_wdata_q};
        end
    end

    // Next-state logic: fsync snapshot, grasp-time frame commit, done-rise completion,
    // command accept and FIFO bookkeeping; sync_reset overrides everything last.
    always_comb begin
        state_d          = state_q;
        rd_ptr_d         = rd_ptr_q;
        wr_ptr_d         = wr_ptr_q;
        count_d          = count_q;
        hold_d           = hold_q;
        snap_type_d      = snap_type_q;
        snap_from_fifo_d = snap_from_fifo_q;
        snap_sec_req_d   = snap_sec_req_q;
        inflight_type_d  = inflight_type_q;
        grasped_d        = grasped_q;
        done_d1_d        = codec_done;
        cmd_pending_d    = cmd_pending_q;
        cmd_inflight_d   = cmd_inflight_q;
        cmd_rw_d         = cmd_rw_q;
        cmd_addr_d       = cmd_addr_q;
        cmd_wdata_d      = cmd_wdata_q;
        cmd_rdata_d      = cmd_rdata_q;
        cmd_ack_d        = 1'b0;
        adc_data_d       = adc_data_q;
        adc_valid_d      = 1'b0;
        underrun_d       = underrun_q;
        pop              = 1'b0;

        if (codec_fsync) begin
            snap_type_d      = state_q;
            snap_from_fifo_d = fifo_nonempty;
            snap_sec_req_d   = codec_write_data[0];
        end

        // Decisions here use only the fsync snapshot, so late pushes/accepts
        // cannot alter the frame already loaded by the core.
        if (codec_write_data_grasp) begin
            grasped_d       = 1'b1;
            inflight_type_d = snap_type_q;
            if (snap_type_q == S_PRI) begin
                if (snap_from_fifo_q) begin
                    pop    = 1'b1;
                    hold_d = fifo_mem[rd_ptr_q];
                end else begin
                    underrun_d = 1'b1;
                end
                state_d = snap_sec_req_q ? S_SEC : S_PRI;
            end else begin
                state_d        = S_PRI;
                cmd_pending_d  = 1'b0;
                cmd_inflight_d = 1'b1;
            end
        end

        if (done_rise && grasped_q) begin
            if (inflight_type_q == S_PRI) begin
                adc_data_d  = codec_read_data;
                adc_valid_d = 1'b1;
            end else begin
                cmd_rdata_d    = cmd_rw_q ? codec_read_data[7:0] : '0;
                cmd_ack_d      = 1'b1;
                cmd_inflight_d = 1'b0;
            end
        end

        if (cmd_req && cmd_ready) begin
            cmd_rw_d      = cmd_rw;
            cmd_addr_d    = cmd_addr;
            cmd_wdata_d   = cmd_wdata;
            cmd_pending_d = 1'b1;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase

        if (sync_reset) begin
            state_d          = S_PRI;
            rd_ptr_d         = '0;
            wr_ptr_d         = '0;
            count_d          = '0;
            hold_d           = '0;
            snap_type_d      = S_PRI;
            snap_from_fifo_d = 1'b0;
            snap_sec_req_d   = 1'b0;
            inflight_type_d  = S_PRI;
            grasped_d        = 1'b0;
            done_d1_d        = 1'b0;
            cmd_pending_d    = 1'b0;
            cmd_inflight_d   = 1'b0;
            cmd_rw_d         = 1'b0;
            cmd_addr_d       = '0;
            cmd_wdata_d      = '0;
            cmd_rdata_d      = '0;
            cmd_ack_d        = 1'b0;
            adc_data_d       = '0;
            adc_valid_d      = 1'b0;
            underrun_d       = 1'b0;
        end
    end

    // DAC sample storage; contents are don't-care until the pointers say otherwise.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= dac_data;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= S_PRI;
            rd_ptr_q         <= '0;
            wr_ptr_q         <= '0;
            count_q          <= '0;
            hold_q           <= '0;
            snap_type_q      <= S_PRI;
            snap_from_fifo_q <= 1'b0;
            snap_sec_req_q   <= 1'b0;
            inflight_type_q  <= S_PRI;
            grasped_q        <= 1'b0;
            done_d1_q        <= 1'b0;
            cmd_pending_q    <= 1'b0;
            cmd_inflight_q   <= 1'b0;
            cmd_rw_q         <= 1'b0;
            cmd_addr_q       <= '0;
            cmd_wdata_q      <= '0;
            cmd_rdata_q      <= '0;
            cmd_ack_q        <= 1'b0;
            adc_data_q       <= '0;
            adc_valid_q      <= 1'b0;
            underrun_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            rd_ptr_q         <= rd_ptr_d;
            wr_ptr_q         <= wr_ptr_d;
            count_q          <= count_d;
            hold_q           <= hold_d;
            snap_type_q      <= snap_type_d;
            snap_from_fifo_q <= snap_from_fifo_d;
            snap_sec_req_q   <= snap_sec_req_d;
            inflight_type_q  <= inflight_type_d;
            grasped_q        <= grasped_d;
            done_d1_q        <= done_d1_d;
            cmd_pending_q    <= cmd_pending_d;
            cmd_inflight_q   <= cmd_inflight_d;
            cmd_rw_q         <= cmd_rw_d;
            cmd_addr_q       <= cmd_addr_d;
            cmd_wdata_q      <= cmd_wdata_d;
            cmd_rdata_q      <= cmd_rdata_d;
            cmd_ack_q        <= cmd_ack_d;
            adc_data_q       <= adc_data_d;
            adc_valid_q      <= adc_valid_d;
            underrun_q       <= underrun_d;
        end
    end

endmodule

// File: tb/tb_si3000_frame_scheduler.sv
// tb_si3000_frame_scheduler
// Directed bench emulating the Si3000 core handshake (fsync, grasp, done level)
// with scoreboard queues for SDI words, ADC samples and register read-back.
module tb_si3000_frame_scheduler;

    logic        clk;
    logic        reset_n;
    logic        sync_reset;
    logic [15:0] dac_data;
    logic        dac_valid;
    logic        dac_ready;
    logic [15:0] adc_data;
    logic        adc_valid;
    logic        cmd_req;
    logic        cmd_rw;
    logic [4:0]  cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        cmd_ready;
    logic        cmd_ack;
    logic [7:0]  cmd_rdata;
    logic        dac_underrun;
    logic [15:0] codec_write_data;
    logic        codec_fsync;
    logic        codec_write_data_grasp;
    logic [15:0] codec_read_data;
    logic        codec_done;

    int tests = 0;
    int fails = 0;

    logic [15:0] exp_words [$];
    logic [15:0] exp_adc   [$];
    logic [7:0]  exp_rd    [$];

    si3000_frame_scheduler #(
        .FIFO_DEPTH(4),
        .WORD_SIZE (16)
    ) dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .sync_reset            (sync_reset),
        .dac_data              (dac_data),
        .dac_valid             (dac_valid),
        .dac_ready             (dac_ready),
        .adc_data              (adc_data),
        .adc_valid             (adc_valid),
        .cmd_req               (cmd_req),
        .cmd_rw                (cmd_rw),
        .cmd_addr              (cmd_addr),
        .cmd_wdata             (cmd_wdata),
        .cmd_ready             (cmd_ready),
        .cmd_ack               (cmd_ack),
        .cmd_rdata             (cmd_rdata),
        .dac_underrun          (dac_underrun),
        .codec_write_data      (codec_write_data),
        .codec_fsync           (codec_fsync),
        .codec_write_data_grasp(codec_write_data_grasp),
        .codec_read_data       (codec_read_data),
        .codec_done            (codec_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic push_sample(input logic [15:0] v);
        @(negedge clk);
        chk1("dac_ready_before_push", dac_ready, 1'b1);
        dac_data  = v;
        dac_valid = 1'b1;
        @(negedge clk);
        dac_valid = 1'b0;
    endtask

    task automatic issue_cmd(input logic rw, input logic [4:0] a, input logic [7:0] wd);
        @(negedge clk);
        chk1("cmd_ready_idle", cmd_ready, 1'b1);
        cmd_req   = 1'b1;
        cmd_rw    = rw;
        cmd_addr  = a;
        cmd_wdata = wd;
        @(negedge clk);
        cmd_req = 1'b0;
        chk1("cmd_ready_busy", cmd_ready, 1'b0);
    endtask

    // push_mode: 0 none, 1 push during fsync cycle, 2 push during grasp cycle
    task automatic run_frame(input logic [15:0] rdata, input bit is_sec,
                             input int unsigned push_mode, input logic [15:0] push_val);
        logic [15:0] e;
        @(negedge clk);
        codec_done  = 1'b0;
        codec_fsync = 1'b1;
        if (push_mode == 1) begin
            dac_data  = push_val;
            dac_valid = 1'b1;
        end
        e = (exp_words.size() != 0) ? exp_words.pop_front() : 16'hDEAD;
        chk16("sdi_word", codec_write_data, e);
        @(negedge clk);
        codec_fsync            = 1'b0;
        dac_valid              = 1'b0;
        codec_write_data_grasp = 1'b1;
        if (push_mode == 2) begin
            dac_data  = push_val;
            dac_valid = 1'b1;
        end
        @(negedge clk);
        codec_write_data_grasp = 1'b0;
        dac_valid              = 1'b0;
        repeat (3) @(negedge clk);
        codec_read_data = rdata;
        codec_done      = 1'b1;
        if (!is_sec) exp_adc.push_back(rdata);
        chk1("adc_quiet_before_rise", adc_valid, 1'b0);
        chk1("ack_quiet_before_rise", cmd_ack, 1'b0);
        @(negedge clk);
        if (!is_sec) begin
            chk1("adc_valid_pulse", adc_valid, 1'b1);
            if (adc_valid) begin
                e = (exp_adc.size() != 0) ? exp_adc.pop_front() : 16'hDEAD;
                chk16("adc_data", adc_data, e);
            end
            chk1("no_ack_in_primary", cmd_ack, 1'b0);
        end else begin
            chk1("cmd_ack_pulse", cmd_ack, 1'b1);
            if (cmd_ack) begin
                e = {8'h00, (exp_rd.size() != 0) ? exp_rd.pop_front() : 8'hDE};
                chk16("cmd_rdata", {8'h00, cmd_rdata}, e);
            end
            chk1("no_adc_in_secondary", adc_valid, 1'b0);
            chk1("cmd_ready_low_at_ack", cmd_ready, 1'b0);
        end
        @(negedge clk);
        chk1("adc_single_pulse", adc_valid, 1'b0);
        chk1("ack_single_pulse", cmd_ack, 1'b0);
        if (is_sec) chk1("cmd_ready_after_ack", cmd_ready, 1'b1);
    endtask

    initial begin
        reset_n                = 1'b0;
        sync_reset             = 1'b0;
        dac_data               = '0;
        dac_valid              = 1'b0;
        cmd_req                = 1'b0;
        cmd_rw                 = 1'b0;
        cmd_addr               = '0;
        cmd_wdata              = '0;
        codec_fsync            = 1'b0;
        codec_write_data_grasp = 1'b0;
        codec_read_data        = '0;
        codec_done             = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        chk1 ("rst_dac_ready", dac_ready, 1'b1);
        chk1 ("rst_cmd_ready", cmd_ready, 1'b1);
        chk1 ("rst_adc_valid", adc_valid, 1'b0);
        chk1 ("rst_cmd_ack", cmd_ack, 1'b0);
        chk1 ("rst_underrun", dac_underrun, 1'b0);
        chk16("rst_word", codec_write_data, 16'h0000);
        chk16("rst_adc_data", adc_data, 16'h0000);
        chk16("rst_cmd_rdata", {8'h00, cmd_rdata}, 16'h0000);
        reset_n = 1'b1;

        // Done rise before any grasp is ignored
        @(negedge clk);
        codec_read_data = 16'h5555;
        codec_done      = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk1("done_without_grasp", adc_valid, 1'b0);
        end
        codec_done = 1'b0;

        // Two samples, LSB forced to the request flag
        push_sample(16'h1235);
        push_sample(16'h4000);
        exp_words.push_back(16'h1234);
        exp_words.push_back(16'h4000);
        run_frame(16'hBEEF, 1'b0, 0, '0);
        run_frame(16'h1111, 1'b0, 0, '0);
        chk16("hold_after_drain", codec_write_data, 16'h4000);
        chk1 ("no_underrun_yet", dac_underrun, 1'b0);
        chk1 ("dac_ready_after_drain", dac_ready, 1'b1);

        // Register write
        push_sample(16'h0100);
        issue_cmd(1'b0, 5'h05, 8'hA5);
        exp_rd.push_back(8'h00);
        exp_words.push_back(16'h0101);
        exp_words.push_back(16'h05A5);
        run_frame(16'h2222, 1'b0, 0, '0);
        chk1("cmd_ready_while_pending", cmd_ready, 1'b0);
        run_frame(16'h00FF, 1'b1, 0, '0);
        chk16("primary_after_secondary", codec_write_data, 16'h0100);

        // Register read
        push_sample(16'h7777);
        issue_cmd(1'b1, 5'h0C, 8'h00);
        exp_rd.push_back(8'h33);
        exp_words.push_back(16'h7777);
        exp_words.push_back(16'h2C00);
        run_frame(16'h0A0A, 1'b0, 0, '0);
        run_frame(16'hAB33, 1'b1, 0, '0);

        // Underrun: push lands between fsync and grasp, goes out next frame
        exp_words.push_back(16'h7776);
        run_frame(16'h0B0B, 1'b0, 1, 16'h5678);
        chk1("underrun_set", dac_underrun, 1'b1);
        exp_words.push_back(16'h5678);
        run_frame(16'h0C0C, 1'b0, 0, '0);
        chk1("underrun_sticky", dac_underrun, 1'b1);

        // sync_reset with a command in flight
        push_sample(16'h1000);
        issue_cmd(1'b0, 5'h01, 8'h11);
        exp_words.push_back(16'h1001);
        run_frame(16'h0D0D, 1'b0, 0, '0);
        push_sample(16'h3000);
        @(negedge clk);
        codec_done  = 1'b0;
        codec_fsync = 1'b1;
        chk16("sec_word_before_flush", codec_write_data, 16'h0111);
        @(negedge clk);
        codec_fsync            = 1'b0;
        codec_write_data_grasp = 1'b1;
        @(negedge clk);
        codec_write_data_grasp = 1'b0;
        chk1("cmd_ready_in_flight", cmd_ready, 1'b0);
        @(negedge clk);
        sync_reset = 1'b1;
        @(negedge clk);
        sync_reset = 1'b0;
        chk1 ("flush_cmd_ready", cmd_ready, 1'b1);
        chk1 ("flush_dac_ready", dac_ready, 1'b1);
        chk1 ("flush_underrun", dac_underrun, 1'b0);
        chk16("flush_word_pri_empty", codec_write_data, 16'h0000);
        codec_read_data = 16'h0099;
        codec_done      = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk1("flush_no_ack", cmd_ack, 1'b0);
            chk1("flush_no_adc", adc_valid, 1'b0);
        end

        // FIFO fill, same-cycle push/pop, pointer wrap
        push_sample(16'h0002);
        push_sample(16'h0004);
        push_sample(16'h0006);
        exp_words.push_back(16'h0002);
        run_frame(16'h1357, 1'b0, 2, 16'h0008);
        push_sample(16'h000A);
        @(negedge clk);
        chk1("fifo_full", dac_ready, 1'b0);
        exp_words.push_back(16'h0004);
        exp_words.push_back(16'h0006);
        exp_words.push_back(16'h0008);
        exp_words.push_back(16'h000A);
        run_frame(16'h2468, 1'b0, 0, '0);
        chk1("not_full_after_pop", dac_ready, 1'b1);
        run_frame(16'h369C, 1'b0, 0, '0);
        run_frame(16'h48D0, 1'b0, 0, '0);
        run_frame(16'h5B04, 1'b0, 0, '0);
        chk16("hold_after_wrap", codec_write_data, 16'h000A);
        chk1 ("no_underrun_after_fill", dac_underrun, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
